// File: rtl/xpmwrap_fifo_arb_pkg.sv
// Shared types and helpers for the xpmwrap FIFO arbiters: the FSM state
// encoding and a round-robin priority search used by the write and read sides.
package xpmwrap_fifo_arb_pkg;

  // Widest requester set the search supports; narrower users zero-pad.
  localparam int RR_MAX_REQ = 16;
  localparam int RR_IDX_W   = 4;

  typedef enum logic [0:0] {
    IDLE = 1'b0,
    LOCK = 1'b1
  } arb_state_e;

  typedef struct packed {
    logic                found;
    logic [RR_IDX_W-1:0] idx;
  } rr_pick_t;

  // First set bit of valid, scanning ptr, ptr+1, ... modulo n.
  // ptr must be < n; bits of valid at or above n are ignored.
  function automatic rr_pick_t rr_pick(input logic [RR_MAX_REQ-1:0] valid,
                                       input logic [RR_IDX_W-1:0]   ptr,
                                       input int                    n);
    rr_pick_t res;
    int       k;
    res = '0;
    for (int i = 0; i < RR_MAX_REQ; i++) begin
      k = int'(ptr) + i;
      if (k >= n) k = k - n;
      if (i < n && !res.found && valid[k[RR_IDX_W-1:0]]) begin
        res.found = 1'b1;
        res.idx   = k[RR_IDX_W-1:0];
      end
    end
    return res;
  endfunction

endpackage

// File: rtl/xpmwrap_rr_arbiter.sv
// Combinational round-robin priority search over NUM_REQ requesters,
// starting at i_ptr. No state; the caller owns the pointer.
module xpmwrap_rr_arbiter
  import xpmwrap_fifo_arb_pkg::*;
#(
  parameter int NUM_REQ  = 4,
  parameter int ID_WIDTH = $clog2(NUM_REQ)
) (
  input  logic [NUM_REQ-1:0]  i_valid,
  input  logic [ID_WIDTH-1:0] i_ptr,
  output logic                o_found,
  output logic [ID_WIDTH-1:0] o_idx
);

  logic [RR_MAX_REQ-1:0] w_valid;
  logic [RR_IDX_W-1:0]   w_ptr;
  rr_pick_t              w_res;
  logic                  w_unused_idx;

  // Zero-pad the requester set and pointer to the helper's fixed width.
  always_comb begin
    w_valid                = '0;
    w_valid[NUM_REQ-1:0]   = i_valid;
    w_ptr                  = '0;
    w_ptr[ID_WIDTH-1:0]    = i_ptr;
  end

  assign w_res        = rr_pick(w_valid, w_ptr, NUM_REQ);
  assign o_found      = w_res.found;
  assign o_idx        = w_res.idx[ID_WIDTH-1:0];
  // Upper index bits are always zero for NUM_REQ < 16.
  assign w_unused_idx = ^w_res.idx;

endmodule

// File: rtl/xpmwrap_fifo_wr_arb.sv
// Round-robin packet arbiter sharing one FIFO write port between NUM_REQ
// valid/ready/last streams. A grant is held until the granted requester's
// last beat, so packets never interleave. One idle cycle separates packets.
module xpmwrap_fifo_wr_arb
  import xpmwrap_fifo_arb_pkg::*;
#(
  parameter  int NUM_REQ    = 4,
  parameter  int DATA_WIDTH = 32,
  parameter  int CNT_WIDTH  = 16,
  localparam int ID_WIDTH   = $clog2(NUM_REQ)
) (
  input  logic                          wr_clk,
  input  logic                          rst,
  input  logic [NUM_REQ-1:0]            req_valid,
  input  logic [NUM_REQ-1:0]            req_last,
  input  logic [NUM_REQ*DATA_WIDTH-1:0] req_data,
  output logic [NUM_REQ-1:0]            req_ready,
  output logic [DATA_WIDTH-1:0]         fifo_din,
  output logic                          fifo_wr_en,
  input  logic                          fifo_full,
  input  logic                          fifo_wr_rst_busy,
  input  logic                          fifo_overflow,
  output logic                          grant_valid,
  output logic [ID_WIDTH-1:0]           grant_id,
  output logic [CNT_WIDTH-1:0]          pkt_count,
  output logic                          ovf_err
);

  arb_state_e                           r_state, w_state_nxt;
  logic [ID_WIDTH-1:0]                  r_rr_ptr;
  logic [ID_WIDTH-1:0]                  r_grant_id;
  logic                                 r_grant_valid;
  logic [CNT_WIDTH-1:0]                 r_pkt_count;
  logic                                 r_ovf_err;

  logic                                 w_found;
  logic [ID_WIDTH-1:0]                  w_pick;
  logic                                 w_can_write;
  logic                                 w_accept;
  logic                                 w_pkt_done;
  logic                                 w_start;
  logic [ID_WIDTH-1:0]                  w_ptr_nxt;
  logic [NUM_REQ-1:0][DATA_WIDTH-1:0]   w_data;

  xpmwrap_rr_arbiter #(
    .NUM_REQ  (NUM_REQ),
    .ID_WIDTH (ID_WIDTH)
  ) u_rr (
    .i_valid (req_valid),
    .i_ptr   (r_rr_ptr),
    .o_found (w_found),
    .o_idx   (w_pick)
  );

  assign w_data      = req_data;
  assign w_can_write = !fifo_full && !fifo_wr_rst_busy;
  assign w_accept    = (r_state == LOCK) && req_valid[r_grant_id] && w_can_write;
  assign w_pkt_done  = w_accept && req_last[r_grant_id];
  assign w_start     = (r_state == IDLE) && !fifo_wr_rst_busy && w_found;
  assign w_ptr_nxt   = (r_grant_id == ID_WIDTH'(NUM_REQ - 1)) ? '0
                                                              : r_grant_id + 1'b1;

  // Next state: arbitrate in IDLE, hold the grant in LOCK until the last beat.
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      IDLE:    if (w_start)    w_state_nxt = LOCK;
      LOCK:    if (w_pkt_done) w_state_nxt = IDLE;
      default: w_state_nxt = IDLE;
    endcase
  end

  // Only the granted requester sees ready, and only when the FIFO can take a beat.
  always_comb begin
    req_ready = '0;
    if (r_state == LOCK) req_ready[r_grant_id] = w_can_write;
  end

  // Zero-latency write path; din follows the granted slice even when idle.
  assign fifo_wr_en  = w_accept;
  assign fifo_din    = w_data[r_grant_id];
  assign grant_valid = r_grant_valid;
  assign grant_id    = r_grant_id;
  assign pkt_count   = r_pkt_count;
  assign ovf_err     = r_ovf_err;

  // State register.
  always_ff @(posedge wr_clk or posedge rst) begin
    if (rst) r_state <= IDLE;
    else     r_state <= w_state_nxt;
  end

  // Grant, round-robin pointer and packet counter; pointer moves past the
  // winner only once its packet completes.
  always_ff @(posedge wr_clk or posedge rst) begin
    if (rst) begin
      r_rr_ptr      <= '0;
      r_grant_id    <= '0;
      r_grant_valid <= 1'b0;
      r_pkt_count   <= '0;
    end else begin
      if (w_start) begin
        r_grant_id    <= w_pick;
        r_grant_valid <= 1'b1;
      end
      if (w_pkt_done) begin
        r_grant_valid <= 1'b0;
        r_rr_ptr      <= w_ptr_nxt;
        r_pkt_count   <= r_pkt_count + 1'b1;
      end
    end
  end

  // Sticky overflow flag; only reset clears it.
  always_ff @(posedge wr_clk or posedge rst) begin
    if (rst) r_ovf_err <= 1'b0;
    else     r_ovf_err <= r_ovf_err | fifo_overflow;
  end

endmodule
